// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, runs the imem request/ready handshake,
// hands instructions to decode and applies execute-stage redirects, halts and faults.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        halt,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        busy,
  output logic        fault,
  output logic [1:0]  fault_code
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_HOLD,
    S_HALTED,
    S_FAULT
  } state_e;

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_TIMEOUT  = 2'b01;
  localparam logic [1:0] FC_MISALIGN = 2'b10;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      inst_q, inst_d;
  logic [31:0]      inst_pc_q, inst_pc_d;
  logic             halt_pending_q, halt_pending_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [1:0]       fault_code_q, fault_code_d;

  // NOTE: every _d is given its hold value first so no path through the case leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    inst_d         = inst_q;
    inst_pc_d      = inst_pc_q;
    halt_pending_d = halt_pending_q;
    wait_cnt_d     = wait_cnt_q;
    fault_code_d   = fault_code_q;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end

      S_FETCH, S_HOLD: begin
        if (halt) halt_pending_d = 1'b1;

        // Redirect outranks both handshakes; whatever was fetched or offered is dropped.
        if (redirect) begin
          if (redirect_pc[1:0] != 2'b00) begin
            state_d      = S_FAULT;
            fault_code_d = FC_MISALIGN;
          end else begin
            pc_d       = redirect_pc;
            wait_cnt_d = '0;
            state_d    = S_FETCH;
          end
        end else if (state_q == S_FETCH) begin
          if (imem_ready) begin
            inst_d     = imem_rdata;
            inst_pc_d  = pc_q;
            wait_cnt_d = '0;
            state_d    = S_HOLD;
          end else if ((TIMEOUT != 0) && (wait_cnt_q == CNT_LAST)) begin
            state_d      = S_FAULT;
            fault_code_d = FC_TIMEOUT;
          end else begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
          end
        end else if (inst_ready) begin
          pc_d    = pc_q + 32'd4;
          state_d = (halt_pending_q || halt) ? S_HALTED : S_FETCH;
        end
      end

      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register samples the
  // pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      pc_q           <= RESET_PC;
      inst_q         <= '0;
      inst_pc_q      <= '0;
      halt_pending_q <= 1'b0;
      wait_cnt_q     <= '0;
      fault_code_q   <= FC_NONE;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      inst_q         <= inst_d;
      inst_pc_q      <= inst_pc_d;
      halt_pending_q <= halt_pending_d;
      wait_cnt_q     <= wait_cnt_d;
      fault_code_q   <= fault_code_d;
    end
  end

  assign imem_req   = (state_q == S_FETCH);
  assign imem_addr  = pc_q;
  assign inst_valid = (state_q == S_HOLD);
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign busy       = (state_q == S_FETCH) || (state_q == S_HOLD);
  assign fault      = (state_q == S_FAULT);
  assign fault_code = fault_code_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: scoreboard of fetched words checked at decode acceptance,
// plus explicit checks of handshakes, redirects, timeout, wrap and halt.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, halt, imem_ready, inst_ready, redirect;
  logic [31:0] imem_rdata, redirect_pc;

  logic        imem_req, inst_valid, busy, fault;
  logic [31:0] imem_addr, inst, inst_pc;
  logic [1:0]  fault_code;

  logic        t4_imem_req, t4_inst_valid, t4_busy, t4_fault;
  logic [31:0] t4_imem_addr, t4_inst, t4_inst_pc;
  logic [1:0]  t4_fault_code;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] exp_pc;
  logic [63:0] sb_q[$];

  always #5 clk = ~clk;

  fetch_ctrl #(.RESET_PC(32'h0), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .start(start), .halt(halt),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .inst_ready(inst_ready), .redirect(redirect), .redirect_pc(redirect_pc),
    .busy(busy), .fault(fault), .fault_code(fault_code)
  );

  // Short-timeout instance sharing the same stimulus.
  fetch_ctrl #(.RESET_PC(32'h0), .TIMEOUT(4)) dut_t4 (
    .clk(clk), .rst(rst), .start(start), .halt(halt),
    .imem_req(t4_imem_req), .imem_addr(t4_imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .inst_valid(t4_inst_valid), .inst(t4_inst),
    .inst_pc(t4_inst_pc), .inst_ready(inst_ready), .redirect(redirect),
    .redirect_pc(redirect_pc), .busy(t4_busy), .fault(t4_fault),
    .fault_code(t4_fault_code)
  );

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string who, input logic req, input logic [31:0] addr,
                             input logic iv, input logic [31:0] ins, input logic [31:0] ipc,
                             input logic bsy, input logic flt, input logic [1:0] fc);
    check({who, "_rst_req"},   32'(req), 32'd0);
    check({who, "_rst_addr"},  addr,     32'h0);
    check({who, "_rst_valid"}, 32'(iv),  32'd0);
    check({who, "_rst_inst"},  ins,      32'h0);
    check({who, "_rst_ipc"},   ipc,      32'h0);
    check({who, "_rst_busy"},  32'(bsy), 32'd0);
    check({who, "_rst_fault"}, 32'(flt), 32'd0);
    check({who, "_rst_code"},  32'(fc),  32'd0);
  endtask

  // One clock: update the scoreboard from the handshakes about to be sampled, then
  // advance to 1 time unit past the rising edge.
  task automatic tick();
    logic [63:0] e;
    if (rst) begin
      sb_q.delete();
      exp_pc = 32'h0;
    end else if (redirect && busy) begin
      if (inst_valid && sb_q.size() != 0) e = sb_q.pop_front();
      if (redirect_pc[1:0] == 2'b00) exp_pc = redirect_pc;
    end else begin
      if (imem_req && imem_ready) sb_q.push_back({exp_pc, imem_rdata});
      if (inst_valid && inst_ready) begin
        n_cmp++;
        assert (sb_q.size() != 0) else begin
          n_fail++;
          $error("FAIL sb_underflow: observed 0 entries expected 1");
        end
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("sb_inst_pc", inst_pc, e[63:32]);
          check("sb_inst",    inst,    e[31:0]);
        end
        exp_pc = exp_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; halt = 1'b0; imem_ready = 1'b0; inst_ready = 1'b0;
    redirect = 1'b0; imem_rdata = '0; redirect_pc = '0; exp_pc = '0;
    tick(); tick();
    rst = 1'b0;
    check_reset("main", imem_req, imem_addr, inst_valid, inst, inst_pc, busy, fault, fault_code);

    // Back-to-back fetch with both handshakes tied high.
    start = 1'b1; imem_ready = 1'b1; inst_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) begin
        check("seq_req",   32'(imem_req),   32'd1);
        check("seq_addr",  imem_addr,       32'(4 * (i / 2)));
        check("seq_valid", 32'(inst_valid), 32'd0);
      end else begin
        check("seq_req",   32'(imem_req),   32'd0);
        check("seq_valid", 32'(inst_valid), 32'd1);
        check("seq_ipc",   inst_pc,         32'(4 * (i / 2)));
      end
      imem_rdata = word_of(exp_pc);
      tick();
    end

    // imem_ready delayed three cycles.
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("wait_req",   32'(imem_req),   32'd1);
      check("wait_addr",  imem_addr,       32'h10);
      check("wait_valid", 32'(inst_valid), 32'd0);
      tick();
    end
    inst_ready = 1'b0; imem_ready = 1'b1; imem_rdata = word_of(32'h10);
    tick();
    check("lat_valid", 32'(inst_valid), 32'd1);
    check("lat_req",   32'(imem_req),   32'd0);
    check("lat_fault", 32'(fault),      32'd0);
    check("lat_inst",  inst,            word_of(32'h10));

    // Decode stall in HOLD for five cycles, accept on the sixth.
    imem_ready = 1'b0; imem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      check("stall_inst",  inst,            word_of(32'h10));
      check("stall_ipc",   inst_pc,         32'h10);
      check("stall_addr",  imem_addr,       32'h10);
      check("stall_valid", 32'(inst_valid), 32'd1);
      tick();
    end
    inst_ready = 1'b1;
    tick();
    check("acc_req",  32'(imem_req), 32'd1);
    check("acc_addr", imem_addr,     32'h14);

    // Redirect in HOLD wins over acceptance.
    inst_ready = 1'b0; imem_ready = 1'b1; imem_rdata = word_of(32'h14);
    tick();
    check("hold_valid", 32'(inst_valid), 32'd1);
    redirect = 1'b1; redirect_pc = 32'h40; inst_ready = 1'b1; imem_ready = 1'b0;
    tick();
    redirect = 1'b0; inst_ready = 1'b0;
    check("redir_valid", 32'(inst_valid), 32'd0);
    check("redir_req",   32'(imem_req),   32'd1);
    check("redir_addr",  imem_addr,       32'h40);

    // Redirect in FETCH wins over imem_ready.
    imem_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h80;
    tick();
    check("fredir_valid", 32'(inst_valid), 32'd0);
    check("fredir_addr",  imem_addr,       32'h80);

    // Misaligned redirect faults and leaves the PC alone.
    imem_ready = 1'b0; redirect_pc = 32'h42;
    tick();
    redirect = 1'b0;
    check("mis_fault", 32'(fault),      32'd1);
    check("mis_code",  32'(fault_code), 32'd2);
    check("mis_req",   32'(imem_req),   32'd0);
    check("mis_busy",  32'(busy),       32'd0);
    check("mis_addr",  imem_addr,       32'h80);
    start = 1'b1; imem_ready = 1'b1; inst_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h100;
    repeat (3) tick();
    start = 1'b0; imem_ready = 1'b0; inst_ready = 1'b0; redirect = 1'b0;
    check("sticky_fault", 32'(fault),      32'd1);
    check("sticky_code",  32'(fault_code), 32'd2);
    check("sticky_req",   32'(imem_req),   32'd0);
    check("sticky_addr",  imem_addr,       32'h80);

    // Timeout: TIMEOUT=4 instance faults after four FETCH cycles, TIMEOUT=16 does not.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset("main", imem_req, imem_addr, inst_valid, inst, inst_pc, busy, fault, fault_code);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("to_pre_fault", 32'(t4_fault),    32'd0);
      check("to_pre_req",   32'(t4_imem_req), 32'd1);
      tick();
    end
    check("to_fault",    32'(t4_fault),      32'd1);
    check("to_code",     32'(t4_fault_code), 32'd1);
    check("to_req",      32'(t4_imem_req),   32'd0);
    check("to_busy",     32'(t4_busy),       32'd0);
    check("to16_fault",  32'(fault),         32'd0);
    check("to16_req",    32'(imem_req),      32'd1);
    repeat (2) tick();
    check("to_sticky",   32'(t4_fault_code), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset("t4", t4_imem_req, t4_imem_addr, t4_inst_valid, t4_inst, t4_inst_pc,
                t4_busy, t4_fault, t4_fault_code);
    check_reset("main", imem_req, imem_addr, inst_valid, inst, inst_pc, busy, fault, fault_code);

    // PC wrap at the top of the address space, with halt taken at acceptance.
    start = 1'b1;
    tick();
    start = 1'b0; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    halt = 1'b1; imem_ready = 1'b1; imem_rdata = word_of(32'hFFFF_FFFC);
    tick();
    halt = 1'b0; imem_ready = 1'b0;
    check("wrap_valid", 32'(inst_valid), 32'd1);
    check("wrap_ipc",   inst_pc,         32'hFFFF_FFFC);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    check("halt_req",   32'(imem_req),   32'd0);
    check("halt_valid", 32'(inst_valid), 32'd0);
    check("halt_busy",  32'(busy),       32'd0);
    check("halt_fault", 32'(fault),      32'd0);
    check("halt_addr",  imem_addr,       32'h0);
    start = 1'b1; imem_ready = 1'b1;
    repeat (3) tick();
    start = 1'b0; imem_ready = 1'b0;
    check("halt_start_req",  32'(imem_req), 32'd0);
    check("halt_start_busy", 32'(busy),     32'd0);
    check("halt_start_addr", imem_addr,     32'h0);
    check("sb_leftover",     32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
